// File: rtl/popcount_seq.sv
// Sequential ones/zeros counter: load the operand, shift it right one bit per cycle,
// and accumulate. Ones mode stops early once no set bits remain in the shifter.
module popcount_seq #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Valor,
  input  logic             modo,
  input  logic             start,
  output logic [CW-1:0]    Cuenta,
  output logic             fin,
  output logic             ocupado
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  q;
  logic [CW-1:0]     acc;
  logic [CW-1:0]     remaining;
  logic              modo_r;
  logic              load;
  logic              early;
  logic              step;

  // The accumulator never exceeds WIDTH, so the add cannot wrap in CW bits.
  function automatic logic [CW-1:0] acc_next(input logic [CW-1:0] a,
                                             input logic          b,
                                             input logic          zeros);
    logic hit;
    hit = zeros ? ~b : b;
    return a + CW'(hit);
  endfunction

  always_comb begin
    load  = start && ((state == IDLE) || (state == DONE));
    early = !modo_r && (q == '0);
    step  = (state == COUNT) && !early;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COUNT;
      COUNT:   if (early || (remaining == CW'(1))) state_nxt = DONE;
      DONE:    if (start) state_nxt = COUNT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= '0;
      acc       <= '0;
      remaining <= '0;
      modo_r    <= 1'b0;
    end else if (load) begin
      q         <= Valor;
      acc       <= '0;
      remaining <= CW'(WIDTH);
      modo_r    <= modo;
    end else if (step) begin
      acc       <= acc_next(acc, q[0], modo_r);
      q         <= q >> 1;
      remaining <= remaining - CW'(1);
    end
  end

  assign Cuenta  = acc;
  assign fin     = (state == DONE);
  assign ocupado = (state == COUNT);

endmodule
